fp_sqrt_seq: RTL and testbench

FP_SQRT_SEQ -- requirements
Module: fp_sqrt_seq

---
 rtl/fp_sqrt_seq.sv | 146 ++++++++++++++
 tb/tb_fp_sqrt_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-style square root, one root bit per cycle by restoring digit recurrence.
// Latency: MAN_W+3 cycles accept-to-out_valid for normal operands, 1 cycle for specials.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Define FP_SQRT_ROUND_EN for round-to-nearest.
module fp_sqrt_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_invalid,
  output logic                   busy
);

  localparam int QW = MAN_W + 2;          // root bits: implicit 1, fraction, guard
  localparam int RW = MAN_W + 4;          // remainder width
  localparam int DW = 2 * QW;             // radicand bits consumed two per cycle
  localparam int CW = $clog2(QW + 1);
  localparam logic [EXP_W-1:0] BIAS_E   = {1'b0, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W+MAN_W:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [RW-1:0]      rem;
  logic [QW-1:0]      root;
  logic [DW-1:0]      rad;
  logic [EXP_W-1:0]   res_exp;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Operand decode and special-case classification at acceptance
  logic                   in_sign, exp_zero, exp_all1, man_zero;
  logic                   is_special, is_invalid;
  logic [EXP_W-1:0]       in_exp;
  logic [MAN_W-1:0]       in_man;
  logic [EXP_W+MAN_W:0]   spec_data;
  logic signed [EXP_W+1:0] e_unb;
  logic [EXP_W-1:0]       half_exp;
  logic [DW-1:0]          rad_init;

  always_comb begin
    in_sign    = in_data[EXP_W+MAN_W];
    in_exp     = in_data[EXP_W+MAN_W-1:MAN_W];
    in_man     = in_data[MAN_W-1:0];
    exp_zero   = (in_exp == '0);
    exp_all1   = (in_exp == EXP_ONES);
    man_zero   = (in_man == '0);
    // Subnormals flush to zero, so an all-zero exponent is treated as zero
    is_invalid = (exp_all1 && !man_zero) || (in_sign && !exp_zero);
    is_special = exp_zero || exp_all1 || in_sign;
    if (is_invalid)    spec_data = QNAN;
    else if (exp_zero) spec_data = {in_sign, {(EXP_W+MAN_W){1'b0}}};
    else               spec_data = {1'b0, EXP_ONES, {MAN_W{1'b0}}};
    // Result exponent is floor(e/2)+bias; odd e doubles the radicand instead
    e_unb    = $signed({2'b00, in_exp}) - $signed({2'b00, BIAS_E});
    half_exp = EXP_W'((e_unb >>> 1) + $signed({2'b00, BIAS_E}));
    if (e_unb[0]) rad_init = {1'b1, in_man, {(MAN_W+3){1'b0}}};
    else          rad_init = {2'b01, in_man, {(MAN_W+2){1'b0}}};
  end

  // One restoring step: bring down two radicand bits, try subtracting 4q+1
  logic [RW-1:0]    rem_sh, trial, rem_nxt;
  logic [QW-1:0]    root_nxt;
  logic             take;
  logic [EXP_W-1:0] fin_exp;
  logic [MAN_W-1:0] fin_frac;

  always_comb begin
    rem_sh   = RW'({rem, rad[DW-1:DW-2]});
    trial    = {1'b0, root[QW-2:0], 2'b01};
    take     = (rem_sh >= trial);
    rem_nxt  = take ? (rem_sh - trial) : rem_sh;
    root_nxt = {root[QW-2:0], take};
`ifdef FP_SQRT_ROUND_EN
    // Guard bit added to fraction; a carry-out bumps the exponent with a zero fraction
    {fin_exp, fin_frac} = {res_exp, root_nxt[QW-2:1]} + {{(EXP_W+MAN_W-1){1'b0}}, root_nxt[0]};
`else
    fin_exp  = res_exp;
    fin_frac = root_nxt[QW-2:1];
`endif
  end

  // Control FSM and datapath registers, including the registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      root        <= '0;
      rad         <= '0;
      res_exp     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_special) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              out_data    <= spec_data;
              out_invalid <= is_invalid;
            end else begin
              state   <= CALC;
              rad     <= rad_init;
              rem     <= '0;
              root    <= '0;
              cnt     <= '0;
              res_exp <= half_exp;
            end
          end
        end
        CALC: begin
          rem  <= rem_nxt;
          root <= root_nxt;
          rad  <= {rad[DW-3:0], 2'b00};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(QW - 1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_data    <= {1'b0, fin_exp, fin_frac};
            out_invalid <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Directed testbench for fp_sqrt_seq at default parameters (binary32).
// Latency is counted so that a result visible right after the accepting edge is 1 cycle.
// Each scenario task performs its own inline comparisons.
module tb_fp_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fp_sqrt_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_invalid(out_invalid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive one operand, wait (bounded) for the result, record it and consume it
  task automatic do_op(input logic [31:0] d, output logic [31:0] r, output logic inv, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    r   = out_data;
    inv = out_invalid;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
    checks++; if (out_invalid !== 1'b0) begin errors++; $display("FAIL reset_out_invalid got=%b want=0", out_invalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_normal;
    logic [31:0] ops  [6] = '{32'h41100000, 32'h40000000, 32'h41800000, 32'h3F800000, 32'h3E800000, 32'h3F000000};
    logic [31:0] exps [6] = '{32'h40400000, 32'h3FB504F3, 32'h40800000, 32'h3F800000, 32'h3F000000, 32'h3F3504F3};
    logic [31:0] r;
    logic inv;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], r, inv, lat);
      checks++; if (r !== exps[i]) begin errors++; $display("FAIL normal_data op=%h got=%h want=%h", ops[i], r, exps[i]); end
      checks++; if (inv !== 1'b0) begin errors++; $display("FAIL normal_invalid op=%h got=%b want=0", ops[i], inv); end
      checks++; if (lat !== 26) begin errors++; $display("FAIL normal_latency op=%h got=%0d want=26", ops[i], lat); end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] r;
    logic inv;
    int lat;
    // sqrt(3) has a zero guard bit, so both builds give the same word
    do_op(32'h40400000, r, inv, lat);
    checks++; if (r !== 32'h3FDDB3D7) begin errors++; $display("FAIL round_sqrt3 got=%h want=3FDDB3D7", r); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL round_latency got=%0d want=26", lat); end
  endtask

  task automatic test_specials;
    logic [31:0] ops  [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hC0800000,
                              32'hFF800000, 32'h00400000, 32'h80000001, 32'h7FC00001};
    logic [31:0] exps [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                              32'h7FC00000, 32'h00000000, 32'h80000000, 32'h7FC00000};
    logic        invs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] r;
    logic inv;
    int lat;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], r, inv, lat);
      checks++; if (r !== exps[i]) begin errors++; $display("FAIL special_data op=%h got=%h want=%h", ops[i], r, exps[i]); end
      checks++; if (inv !== invs[i]) begin errors++; $display("FAIL special_invalid op=%h got=%b want=%b", ops[i], inv, invs[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_latency op=%h got=%0d want=1", ops[i], lat); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [31:0] r;
    logic inv;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h41100000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_result_timeout got=%b want=1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0]; in_data = 32'h41800000;
      @(posedge clk); #1;
      checks++; if (out_data !== 32'h40400000) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h want=40400000", c, out_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_consume_cycle_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_in_ready got=%b want=1", in_ready); end
    // Pulsed in_valid must not have started a hidden operation
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_ghost_op valid=%b busy=%b want=0/0", out_valid, busy); end
    do_op(32'h41800000, r, inv, lat);
    checks++; if (r !== 32'h40800000) begin errors++; $display("FAIL bp_next_op got=%h want=40800000", r); end
  endtask

  task automatic test_reset_mid_calc;
    logic [31:0] r;
    logic inv;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h41100000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_result got=%b want=0", out_valid); end
    do_op(32'h41800000, r, inv, lat);
    checks++; if (r !== 32'h40800000) begin errors++; $display("FAIL midrst_next_data got=%h want=40800000", r); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL midrst_next_latency got=%0d want=26", lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2;
    logic i1, i2;
    int l1, l2;
    do_op(32'hC0800000, r1, i1, l1);
    do_op(32'h41100000, r2, i2, l2);
    checks++; if (r1 !== 32'h7FC00000 || i1 !== 1'b1) begin errors++; $display("FAIL b2b_first got=%h/%b want=7FC00000/1", r1, i1); end
    checks++; if (r2 !== 32'h40400000 || i2 !== 1'b0) begin errors++; $display("FAIL b2b_second got=%h/%b want=40400000/0", r2, i2); end
    checks++; if (l2 !== 26) begin errors++; $display("FAIL b2b_latency got=%0d want=26", l2); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_rounding;
    test_specials;
    test_backpressure;
    test_reset_mid_calc;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
